cpu_datapath: RTL and testbench

Datapath stage directly downstream of the CPU controller FSM. It consumes the controller's strobes (mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr, halt) and phase code cs. It holds the program counter, instruction register and accumulator, and contains the ALU and the memory address mux. It returns opcode and zero to the controller and drives the single-port program/data memory.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/cpu_datapath_if.sv | 21 ++
 rtl/cpu_alu.sv | 25 ++
 rtl/cpu_datapath.sv | 68 ++++++
 tb/tb_cpu_datapath.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU controller and datapath: opcodes, phase codes
// and default widths.
package cpu_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    localparam logic [2:0] INST_ADDR  = 3'd0;
    localparam logic [2:0] INST_FETCH = 3'd1;
    localparam logic [2:0] INST_LOAD  = 3'd2;
    localparam logic [2:0] IDLE       = 3'd3;
    localparam logic [2:0] OP_ADDR    = 3'd4;
    localparam logic [2:0] OP_FETCH   = 3'd5;
    localparam logic [2:0] ALU_OP     = 3'd6;
    localparam logic [2:0] STORE      = 3'd7;

    // Phases 4..7 address the operand named by IR; 0..3 address the instruction at PC.
    function automatic logic is_operand_phase(input logic [2:0] cs);
        return cs >= OP_ADDR;
    endfunction

endpackage

// File: rtl/cpu_datapath_if.sv
// Single-port program/data memory bus between the datapath (master) and memory (slave).
interface cpu_datapath_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_re;
    logic              mem_we;

    modport master (
        output mem_addr, mem_wdata, mem_re, mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_re, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU: combines the accumulator with the memory operand per opcode.
import cpu_pkg::*;

module cpu_alu #(
    parameter int DATA_W = 8
) (
    input  opcode_t           opcode,
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] alu_out
);

    always_comb begin
        // NOTE: default assignment first so no path leaves alu_out unassigned (no latch).
        alu_out = ac;
        unique case (opcode)
            ADD:     alu_out = ac + mem_rdata;
            AND:     alu_out = ac & mem_rdata;
            XOR:     alu_out = ac ^ mem_rdata;
            LDA:     alu_out = mem_rdata;
            default: alu_out = ac;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// CPU datapath: PC, IR, accumulator, ALU and memory address mux driven by the
// controller's strobes and phase code.
import cpu_pkg::*;

module cpu_datapath #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              load_ir,
    input  logic              inc_pc,
    input  logic              load_pc,
    input  logic              load_ac,
    input  logic              mem_wr,
    input  logic              halt,
    input  logic [2:0]        cs,
    cpu_datapath_if.master    mem,
    output opcode_t           opcode,
    output logic              zero,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ac,
    output logic              halted
);

    if (DATA_W != ADDR_W + 3) begin : g_bad_width
        $error("cpu_datapath: DATA_W must equal ADDR_W + 3");
    end

    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] alu_out;

    assign opcode = opcode_t'(ir[DATA_W-1 -: 3]);
    assign zero   = (ac == '0);

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode    (opcode),
        .ac        (ac),
        .mem_rdata (mem.mem_rdata),
        .alu_out   (alu_out)
    );

    assign mem.mem_addr  = is_operand_phase(cs) ? ir[ADDR_W-1:0] : pc;
    assign mem.mem_wdata = ac;
    assign mem.mem_re    = mem_rd & ~halted;
    assign mem.mem_we    = mem_wr & ~halted;

    // Strobes on the halt edge still take effect; halted gates them from the next edge on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            pc     <= '0;
            ir     <= '0;
            ac     <= '0;
            halted <= 1'b0;
        end else begin
            if (halt) halted <= 1'b1;
            if (!halted) begin
                if (load_ir) ir <= mem.mem_rdata;
                if (load_ac) ac <= alu_out;
                if (load_pc)     pc <= ir[ADDR_W-1:0];
                else if (inc_pc) pc <= pc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath with hand-computed expectations.
import cpu_pkg::*;

module tb_cpu_datapath;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mem_rd = 1'b0, load_ir = 1'b0, inc_pc = 1'b0, load_pc = 1'b0;
    logic       load_ac = 1'b0, mem_wr = 1'b0, halt = 1'b0;
    logic [2:0] cs = 3'd0;
    opcode_t    opcode;
    logic       zero;
    logic [4:0] pc;
    logic [7:0] ac;
    logic       halted;

    int errors = 0;
    int checks = 0;

    cpu_datapath_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    cpu_datapath #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .mem_rd  (mem_rd),
        .load_ir (load_ir),
        .inc_pc  (inc_pc),
        .load_pc (load_pc),
        .load_ac (load_ac),
        .mem_wr  (mem_wr),
        .halt    (halt),
        .cs      (cs),
        .mem     (bus.master),
        .opcode  (opcode),
        .zero    (zero),
        .pc      (pc),
        .ac      (ac),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        {mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, halt} = '0;
    endtask

    initial begin
        bus.mem_rdata = 8'h00;
        #2;
        check("rst_pc", pc, 5'd0);
        check("rst_ac", ac, 8'h00);
        check("rst_zero", zero, 1'b1);
        check("rst_addr", bus.mem_addr, 5'd0);
        check("rst_we", bus.mem_we, 1'b0);
        check("rst_re", bus.mem_re, 1'b0);
        check("rst_halted", halted, 1'b0);

        // 1: build ac=0x5A, pc=7, then reset between edges
        rst = 1'b1;
        bus.mem_rdata = 8'hA0; load_ir = 1'b1;
        step();
        check("lda_opcode", opcode, 3'd5);
        load_ir = 1'b0; bus.mem_rdata = 8'h5A; load_ac = 1'b1;
        step();
        check("lda_ac", ac, 8'h5A);
        check("lda_zero", zero, 1'b0);
        load_ac = 1'b0; inc_pc = 1'b1;
        for (int i = 0; i < 7; i++) step();
        inc_pc = 1'b0;
        check("pc_7", pc, 5'd7);
        #1 rst = 1'b0;
        #1;
        check("async_pc", pc, 5'd0);
        check("async_ac", ac, 8'h00);
        check("async_op", opcode, 3'd0);
        check("async_zero", zero, 1'b1);

        // 2: fetch phases and address mux
        #1 rst = 1'b1;
        inc_pc = 1'b1;
        for (int i = 0; i < 3; i++) step();
        inc_pc = 1'b0;
        cs = 3'd0; #1 check("mux_cs0", bus.mem_addr, 5'd3);
        cs = 3'd1; #1 check("mux_cs1", bus.mem_addr, 5'd3);
        cs = 3'd2; bus.mem_rdata = 8'hA5; load_ir = 1'b1;
        #1 check("mux_cs2", bus.mem_addr, 5'd3);
        step();
        load_ir = 1'b0;
        check("fetch_op", opcode, 3'd5);
        cs = 3'd3; #1 check("mux_cs3", bus.mem_addr, 5'd3);
        cs = 3'd4; #1 check("mux_cs4", bus.mem_addr, 5'd5);

        // 3: ALU ops and zero latency
        bus.mem_rdata = 8'hF0; load_ac = 1'b1;
        step();
        check("ac_f0", ac, 8'hF0);
        load_ac = 1'b0; bus.mem_rdata = 8'h40; load_ir = 1'b1;
        step();
        load_ir = 1'b0; bus.mem_rdata = 8'h20; load_ac = 1'b1;
        step();
        check("add_ac", ac, 8'h10);
        check("add_zero", zero, 1'b0);
        load_ac = 1'b0; bus.mem_rdata = 8'h80; load_ir = 1'b1;
        step();
        load_ir = 1'b0; bus.mem_rdata = 8'h10; load_ac = 1'b1;
        #1 check("zero_not_alu", zero, 1'b0);
        step();
        load_ac = 1'b0;
        check("xor_ac", ac, 8'h00);
        check("xor_zero", zero, 1'b1);
        bus.mem_rdata = 8'hA0; load_ir = 1'b1;
        step();
        load_ir = 1'b0; bus.mem_rdata = 8'hCC; load_ac = 1'b1;
        step();
        load_ac = 1'b0; bus.mem_rdata = 8'h60; load_ir = 1'b1;
        step();
        load_ir = 1'b0; bus.mem_rdata = 8'hAA; load_ac = 1'b1;
        step();
        check("and_ac", ac, 8'h88);
        load_ac = 1'b0; bus.mem_rdata = 8'h20; load_ir = 1'b1;
        step();
        load_ir = 1'b0; bus.mem_rdata = 8'h13; load_ac = 1'b1;
        step();
        load_ac = 1'b0;
        check("skz_hold", ac, 8'h88);

        // 4: JMP priority over increment (pc 3 -> 4 while IR loads 0xFC)
        bus.mem_rdata = 8'hFC; load_ir = 1'b1; inc_pc = 1'b1;
        step();
        load_ir = 1'b0;
        check("jmp_pre_pc", pc, 5'd4);
        load_pc = 1'b1;
        step();
        clear_strobes();
        check("jmp_pc", pc, 5'h1C);

        // 5: PC wrap and store
        inc_pc = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("pc_31", pc, 5'd31);
        step();
        inc_pc = 1'b0;
        check("pc_wrap", pc, 5'd0);
        bus.mem_rdata = 8'hA0; load_ir = 1'b1;
        step();
        load_ir = 1'b0; bus.mem_rdata = 8'h3C; load_ac = 1'b1;
        step();
        load_ac = 1'b0; bus.mem_rdata = 8'hC9; load_ir = 1'b1;
        step();
        load_ir = 1'b0;
        cs = 3'd7; mem_wr = 1'b1; mem_rd = 1'b1;
        #1;
        check("sto_addr", bus.mem_addr, 5'd9);
        check("sto_wdata", bus.mem_wdata, 8'h3C);
        check("sto_we", bus.mem_we, 1'b1);
        check("sto_re", bus.mem_re, 1'b1);
        check("sto_op", opcode, 3'd6);
        clear_strobes();

        // 6: halt applies coincident strobes, then freezes state
        halt = 1'b1; inc_pc = 1'b1;
        step();
        halt = 1'b0;
        check("halt_set", halted, 1'b1);
        check("halt_edge_pc", pc, 5'd1);
        load_ac = 1'b1; load_ir = 1'b1; mem_wr = 1'b1; mem_rd = 1'b1; load_pc = 1'b1;
        bus.mem_rdata = 8'h77;
        for (int i = 0; i < 4; i++) begin
            step();
            check("halt_pc", pc, 5'd1);
            check("halt_ac", ac, 8'h3C);
            check("halt_ir_addr", bus.mem_addr, 5'd9);
            check("halt_op", opcode, 3'd6);
            check("halt_we", bus.mem_we, 1'b0);
            check("halt_re", bus.mem_re, 1'b0);
            check("halt_sticky", halted, 1'b1);
        end
        clear_strobes();
        rst = 1'b0;
        #1;
        check("unhalt", halted, 1'b0);
        check("unhalt_pc", pc, 5'd0);
        #1 rst = 1'b1; inc_pc = 1'b1;
        step();
        clear_strobes();
        check("post_rst_inc", pc, 5'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, expected finish before 50000 ns");
        $fatal(1, "timeout");
    end

endmodule
